// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit common-anode multiplexed seven-segment driver.
// Latency: anode/segment/dp are registered, one clock behind presc/digit_idx.
// Backpressure: none; loads are always accepted and held until the frame boundary.
//
// Ports:
//   clockIn    - system clock, rising edge
//   reset      - synchronous, active-low
//   load       - capture strobe for value/dp_in into the shadow register
//   value      - four hex digits, [3:0] = digit 0 (rightmost)
//   dp_in      - decimal point request per digit (1 = lit)
//   digit_en   - per-digit enable (0 = digit kept dark)
//   anode      - active-low digit select
//   segment    - active-low segments {g,f,e,d,c,b,a}
//   dp         - active-low decimal point
//   pending    - a loaded value is waiting for the frame boundary
//   frame_tick - one-cycle pulse after the digit-3 slot ends
//
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to suppress leading
// zeros on digits 3..1 (digit 0 always shown).

module seg7_scan_driver #(
  parameter int SCAN_BITS  = 16,
  parameter int GAP_CYCLES = 64
) (
  input  logic        clockIn,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  output logic [3:0]  anode,
  output logic [6:0]  segment,
  output logic        dp,
  output logic        pending,
  output logic        frame_tick
);

  localparam logic [SCAN_BITS-1:0] GAP_LIM = SCAN_BITS'(GAP_CYCLES);

  logic [SCAN_BITS-1:0] presc_q, presc_d;
  logic [1:0]           digit_idx_q, digit_idx_d;
  logic [15:0]          shadow_q, shadow_d;
  logic [15:0]          disp_q, disp_d;
  logic [3:0]           shadow_dp_q, shadow_dp_d;
  logic [3:0]           disp_dp_q, disp_dp_d;
  logic                 pending_q, pending_d;
  logic [3:0]           anode_q, anode_d;
  logic [6:0]           segment_q, segment_d;
  logic                 dp_q, dp_d;
  logic                 frame_tick_q, frame_tick_d;

  logic                 wrap;
  logic                 frame_end;
  logic                 in_gap;
  logic                 lit;
  logic [3:0]           cur_nib;
  logic [3:0]           blank;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // A zero-length gap would make "presc < 0" a constant compare; handle it structurally.
  generate
    if (GAP_CYCLES == 0) begin : g_nogap
      assign in_gap = 1'b0;
    end else begin : g_gap
      assign in_gap = (presc_q < GAP_LIM);
    end
  endgenerate

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Chain from the top digit down: a digit is blank only if it and every
  // digit above it are zero with no decimal point requested.
  always_comb begin
    blank    = 4'b0000;
    blank[3] = (disp_q[15:12] == 4'h0) && !disp_dp_q[3];
    blank[2] = blank[3] && (disp_q[11:8] == 4'h0) && !disp_dp_q[2];
    blank[1] = blank[2] && (disp_q[7:4] == 4'h0) && !disp_dp_q[1];
  end
`else
  assign blank = 4'b0000;
`endif

  always_comb begin
    presc_d      = presc_q + 1'b1;
    wrap         = (presc_q == {SCAN_BITS{1'b1}});
    digit_idx_d  = wrap ? digit_idx_q + 2'd1 : digit_idx_q;
    frame_end    = wrap && (digit_idx_q == 2'd3);
    frame_tick_d = frame_end;

    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;
    pending_d   = pending_q;

    if (load) begin
      shadow_d    = value;
      shadow_dp_d = dp_in;
      pending_d   = 1'b1;
    end

    // Commit only at the frame boundary so a frame never mixes old and new
    // digits. A load on this very edge bypasses the shadow straight to disp.
    if (frame_end) begin
      if (load) begin
        disp_d    = value;
        disp_dp_d = dp_in;
      end else if (pending_q) begin
        disp_d    = shadow_q;
        disp_dp_d = shadow_dp_q;
      end
      pending_d = 1'b0;
    end

    cur_nib   = disp_q[{digit_idx_q, 2'b00} +: 4];
    lit       = digit_en[digit_idx_q] && !in_gap && !blank[digit_idx_q];
    anode_d   = 4'b1111;
    if (lit) anode_d[digit_idx_q] = 1'b0;
    segment_d = lit ? hex_to_seg(cur_nib) : 7'b1111111;
    dp_d      = lit ? ~disp_dp_q[digit_idx_q] : 1'b1;
  end

  always_ff @(posedge clockIn) begin
    if (!reset) begin
      presc_q      <= '0;
      digit_idx_q  <= 2'd0;
      shadow_q     <= 16'h0000;
      disp_q       <= 16'h0000;
      shadow_dp_q  <= 4'h0;
      disp_dp_q    <= 4'h0;
      pending_q    <= 1'b0;
      anode_q      <= 4'b1111;
      segment_q    <= 7'b1111111;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      digit_idx_q  <= digit_idx_d;
      shadow_q     <= shadow_d;
      disp_q       <= disp_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_dp_q    <= disp_dp_d;
      pending_q    <= pending_d;
      anode_q      <= anode_d;
      segment_q    <= segment_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign anode      = anode_q;
  assign segment    = segment_q;
  assign dp         = dp_q;
  assign pending    = pending_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed bench for seg7_scan_driver (SCAN_BITS=4, GAP_CYCLES=2).
// Inputs driven and outputs sampled on the falling edge of clockIn.
// Each slot is 16 clocks, a frame is 64 clocks.

module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [3:0]  anode;
  logic [6:0]  segment;
  logic        dp;
  logic        pending;
  logic        frame_tick;

  int tests = 0;
  int fails = 0;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_F   = 7'b0001110;

  seg7_scan_driver #(.SCAN_BITS(4), .GAP_CYCLES(2)) dut (
    .clockIn   (clk),
    .reset     (reset),
    .load      (load),
    .value     (value),
    .dp_in     (dp_in),
    .digit_en  (digit_en),
    .anode     (anode),
    .segment   (segment),
    .dp        (dp),
    .pending   (pending),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the next sample where frame_tick is high (n = 0 of a new frame).
  task automatic wait_frame(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_tick) begin
        found = 1'b1;
        break;
      end
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL %s frame_tick timeout: got none, want pulse within 200 clocks", tag);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; load = 1'b0; value = 16'h0; dp_in = 4'h0; digit_en = 4'hF;
    step(3);
    tests++;
    if (anode !== 4'b1111) begin fails++; $display("FAIL reset_anode: got %b want 1111", anode); end
    tests++;
    if (segment !== SEG_OFF) begin fails++; $display("FAIL reset_segment: got %b want 1111111", segment); end
    tests++;
    if (dp !== 1'b1) begin fails++; $display("FAIL reset_dp: got %b want 1", dp); end
    tests++;
    if (pending !== 1'b0) begin fails++; $display("FAIL reset_pending: got %b want 0", pending); end
    tests++;
    if (frame_tick !== 1'b0) begin fails++; $display("FAIL reset_frame_tick: got %b want 0", frame_tick); end
    reset = 1'b1;
    step(2);
    tests++;
    if (anode !== 4'b1111) begin fails++; $display("FAIL release_gap_anode: got %b want 1111", anode); end
    step(1);
    tests++;
    if (anode !== 4'b1110) begin fails++; $display("FAIL release_first_anode: got %b want 1110", anode); end
    tests++;
    if (segment !== SEG_0) begin fails++; $display("FAIL release_first_segment: got %b want %b", segment, SEG_0); end
  endtask

  task automatic test_scan;
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an  [4];
    exp_seg[0] = SEG_4; exp_seg[1] = SEG_3; exp_seg[2] = SEG_2; exp_seg[3] = SEG_1;
    exp_an[0] = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1011; exp_an[3] = 4'b0111;
    load = 1'b1; value = 16'h1234;
    step(1);
    load = 1'b0;
    tests++;
    if (pending !== 1'b1) begin fails++; $display("FAIL scan_pending: got %b want 1", pending); end
    wait_frame("scan");
    for (int d = 0; d < 4; d++) begin
      step(1);
      tests++;
      if (anode !== 4'b1111 || segment !== SEG_OFF) begin
        fails++; $display("FAIL scan_gap d%0d: got %b/%b want 1111/1111111", d, anode, segment);
      end
      step(1);
      tests++;
      if (anode !== 4'b1111) begin fails++; $display("FAIL scan_gap2 d%0d: got %b want 1111", d, anode); end
      step(1);
      tests++;
      if (anode !== exp_an[d] || segment !== exp_seg[d]) begin
        fails++; $display("FAIL scan_drive d%0d: got %b/%b want %b/%b", d, anode, segment, exp_an[d], exp_seg[d]);
      end
      step(13);
      tests++;
      if (anode !== exp_an[d]) begin fails++; $display("FAIL scan_last d%0d: got %b want %b", d, anode, exp_an[d]); end
      if (d == 3) begin
        tests++;
        if (frame_tick !== 1'b1) begin fails++; $display("FAIL scan_tick_period: got %b want 1", frame_tick); end
      end else begin
        tests++;
        if (frame_tick !== 1'b0) begin fails++; $display("FAIL scan_tick_mid d%0d: got %b want 0", d, frame_tick); end
      end
    end
  endtask

  // Starts at n = 0 of a frame showing 1234.
  task automatic test_tear_free;
    step(5);
    load = 1'b1; value = 16'hABCD;
    step(1);
    load = 1'b0;
    tests++;
    if (pending !== 1'b1) begin fails++; $display("FAIL tear_pending1: got %b want 1", pending); end
    step(10);
    load = 1'b1; value = 16'h00F0;
    step(1);
    load = 1'b0;
    step(2);
    tests++;
    if (segment !== SEG_3) begin fails++; $display("FAIL tear_old_digit1: got %b want %b", segment, SEG_3); end
    step(44);
    tests++;
    if (pending !== 1'b1) begin fails++; $display("FAIL tear_pending63: got %b want 1", pending); end
    step(1);
    tests++;
    if (frame_tick !== 1'b1 || pending !== 1'b0) begin
      fails++; $display("FAIL tear_commit: got tick=%b pending=%b want tick=1 pending=0", frame_tick, pending);
    end
    for (int d = 0; d < 4; d++) begin
      step(3);
      tests++;
      if (segment !== ((d == 1) ? SEG_F : SEG_0)) begin
        fails++; $display("FAIL tear_new d%0d: got %b want %b", d, segment, (d == 1) ? SEG_F : SEG_0);
      end
      step(13);
    end
  endtask

  // Starts at n = 0; load is presented on the 64th edge (the boundary).
  task automatic test_back_to_back;
    step(63);
    load = 1'b1; value = 16'h5555;
    step(1);
    load = 1'b0;
    tests++;
    if (frame_tick !== 1'b1 || pending !== 1'b0) begin
      fails++; $display("FAIL b2b_commit: got tick=%b pending=%b want tick=1 pending=0", frame_tick, pending);
    end
    for (int d = 0; d < 4; d++) begin
      step(3);
      tests++;
      if (segment !== SEG_5) begin fails++; $display("FAIL b2b_digit d%0d: got %b want %b", d, segment, SEG_5); end
      step(13);
    end
  endtask

  task automatic test_enables_dp;
    logic [3:0] exp_an [4];
    exp_an[0] = 4'b1110; exp_an[1] = 4'b1111; exp_an[2] = 4'b1011; exp_an[3] = 4'b1111;
    digit_en = 4'b0101;
    step(4);
    load = 1'b1; value = 16'h5555; dp_in = 4'b0001;
    step(1);
    load = 1'b0; dp_in = 4'b0000;
    wait_frame("en_dp");
    for (int d = 0; d < 4; d++) begin
      step(3);
      tests++;
      if (anode !== exp_an[d]) begin fails++; $display("FAIL en_anode d%0d: got %b want %b", d, anode, exp_an[d]); end
      tests++;
      if (dp !== ((d == 0) ? 1'b0 : 1'b1)) begin
        fails++; $display("FAIL en_dp d%0d: got %b want %b", d, dp, (d == 0) ? 1'b0 : 1'b1);
      end
      tests++;
      if (segment !== ((d == 1 || d == 3) ? SEG_OFF : SEG_5)) begin
        fails++; $display("FAIL en_segment d%0d: got %b want %b", d, segment, (d == 1 || d == 3) ? SEG_OFF : SEG_5);
      end
      step(13);
    end
    digit_en = 4'hF;
  endtask

  task automatic test_leading_zero;
    logic [3:0] exp_an  [4];
    logic [6:0] exp_seg [4];
    exp_an[0] = 4'b1110; exp_an[1] = 4'b1101;
    exp_seg[0] = SEG_0; exp_seg[1] = SEG_7;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    exp_an[2] = 4'b1111; exp_an[3] = 4'b1111;
    exp_seg[2] = SEG_OFF; exp_seg[3] = SEG_OFF;
`else
    exp_an[2] = 4'b1011; exp_an[3] = 4'b0111;
    exp_seg[2] = SEG_0; exp_seg[3] = SEG_0;
`endif
    load = 1'b1; value = 16'h0070; dp_in = 4'h0;
    step(1);
    load = 1'b0;
    wait_frame("lzb");
    for (int d = 0; d < 4; d++) begin
      step(3);
      tests++;
      if (anode !== exp_an[d] || segment !== exp_seg[d]) begin
        fails++; $display("FAIL lzb d%0d: got %b/%b want %b/%b", d, anode, segment, exp_an[d], exp_seg[d]);
      end
      step(13);
    end
  endtask

  // Reset mid-frame with a value pending: pending is dropped and disp is zero.
  task automatic test_reset_midframe;
    step(20);
    load = 1'b1; value = 16'h1111;
    step(1);
    load = 1'b0;
    reset = 1'b0;
    step(1);
    tests++;
    if (pending !== 1'b0 || anode !== 4'b1111) begin
      fails++; $display("FAIL midreset: got pending=%b anode=%b want 0/1111", pending, anode);
    end
    reset = 1'b1;
    wait_frame("midreset");
    step(3);
    tests++;
    if (segment !== SEG_0 || anode !== 4'b1110) begin
      fails++; $display("FAIL midreset_display: got %b/%b want %b/1110", segment, anode, SEG_0);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tear_free();
    test_back_to_back();
    test_enables_dp();
    test_leading_zero();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Drives a 4-digit, common-anode, multiplexed seven-segment display from a 16-bit hex value.
- Sits downstream of the 4-bit down-counter and other value producers.
- Latches new values via a load strobe, commits them only at frame boundaries (no tearing), scans digits with a programmable prescaler and an inter-digit blanking gap (anti-ghosting).
- Segment, anode and DP outputs are registered and active-low.

Parameters:
- SCAN_BITS, 16, prescaler width; each digit slot lasts S = 2^SCAN_BITS clocks.
- GAP_CYCLES, 64, clocks at the start of each slot with all anodes off; 0 = no gap; must be < S.

Ports:
- clockIn  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low
- load  input  1  capture strobe for value/dp_in
- value  input  16  hex digits; [3:0] = digit 0 (rightmost), [15:12] = digit 3
- dp_in  input  4  decimal point request per digit, 1 = lit
- digit_en  input  4  per-digit enable, 0 = digit kept dark
- anode  output  4  active-low digit select
- segment  output  7  active-low segments, bit order {g,f,e,d,c,b,a}
- dp  output  1  active-low decimal point
- pending  output  1  a loaded value is waiting for the frame boundary
- frame_tick  output  1  one-cycle pulse when the digit-3 slot ends

Behaviour:
- Reset is synchronous, active-low: clockIn with reset=0 clears the following.
  - presc=0, digit_idx=0, shadow=0, disp=0, shadow_dp=0, disp_dp=0, pending=0.
  - anode=4'b1111, segment=7'b1111111, dp=1, frame_tick=0.
  - Reset mid-frame discards any pending value; the display restarts at digit 0 in its gap.
- Prescaler: presc increments every clock and wraps at S-1 -> 0.
- When presc wraps, digit_idx increments mod 4 (3 -> 0).
- Scan state per slot:
  - GAP: presc < GAP_CYCLES; all anodes high.
  - DRIVE: presc >= GAP_CYCLES; anode[digit_idx]=0 if digit_en[digit_idx]=1, else all high.
- Load: load=1 on an edge captures value -> shadow and dp_in -> shadow_dp, and sets pending=1.
  - Repeated loads before commit overwrite the shadow; the last one wins.
- Commit happens on the edge where presc wraps and digit_idx = 3 (frame boundary).
  - If pending: disp <= shadow, disp_dp <= shadow_dp, pending <= 0.
  - load on that same edge: the newly presented value goes to both shadow and disp; pending ends 0.
  - frame_tick = 1 for exactly the cycle following that edge.
- Decode, registered, from disp digit [digit_idx]:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - dp = ~disp_dp[digit_idx] during DRIVE, else 1.
  - segment = 7'b1111111 during GAP or when the digit is disabled.
- Latency: anode/segment/dp reflect presc/digit_idx of the previous cycle (1-clock registered). Committed data is visible from the first DRIVE of digit 0 in the new frame.
- GAP_CYCLES=0: the anode is driven for all S cycles of the slot.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN (leading-zero suppression).
- Defined:
  - Digit k (k=3..1) is forced dark (anode high, segment all ones, dp=1) when disp digits k..3 are all zero and disp_dp bits k..3 are all zero.
  - Digit 0 is never suppressed.
- Undefined: all enabled digits are shown, including leading zeros.

Test Plan:
- Bench uses SCAN_BITS=4, GAP_CYCLES=2 (S=16).
- Reset: hold reset=0 for 3 clocks -> anode=1111, segment=1111111, dp=1, pending=0, frame_tick=0. Release -> first low anode is 1110, visible 3 cycles after release.
- Scan order and gap: value=16'h1234, load pulse, all digit_en=1.
  - After commit: digit0 shows 0011001 with anode 1110; digit1 0110000 / 1101; digit2 0100100 / 1011; digit3 1111001 / 0111.
  - Each slot shows 2 dark cycles followed by 14 driven cycles; frame_tick pulses every 64 clocks.
- Tear-free commit: load 16'hABCD mid-frame, then load 16'h00F0 before the boundary.
  - pending=1 until the boundary; displayed digits stay old until then.
  - The next frame shows F on digit 1 and 0 on the other digits; ABCD never appears.
- Simultaneous load and boundary: assert load with 16'h5555 on the wrap edge of digit 3 -> next frame shows 5 on all digits, pending=0.
- Enables and DP: digit_en=4'b0101, dp_in=4'b0001 -> digits 1 and 3 stay dark (anode high); digit 0 dp=0; digit 2 dp=1.
- Leading-zero blanking (macro defined): value=16'h0070 -> digits 3 and 2 dark; digit 1 shows 7; digit 0 shows 0. Without the macro -> all four digits are lit.
